// File: rtl/joypad_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joypad_pkg
// Description : Shared button indices and helpers for the joypad port block.
// Revision    : 1.0 - initial release
// ============================================================================
package joypad_pkg;

    localparam int BTN_BITS   = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Cycles per autofire half-period; 0 means autofire is disabled.
    function automatic int autofire_div(input int clk_hz, input int hz);
        if (hz == 0) begin
            return 0;
        end
        return clk_hz / (2 * hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/joypad_port_ctrl_shift_port.sv
`default_nettype none
// ============================================================================
// Module      : joypad_shift_port
// Description : One NES controller serial port: strobe load, falling-edge shift.
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_shift_port
    import joypad_pkg::*;
#(
    parameter logic C_FILL_BIT = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_strobe,
    input  logic                i_clock,
    input  logic [BTN_BITS-1:0] i_load,
    output logic                o_data
);

    logic [BTN_BITS-1:0] r_sr;
    logic                r_clock_prev;
    logic                w_fall;

    assign w_fall = r_clock_prev & ~i_clock;

    // History always tracks the port clock so a strobe-masked edge is not replayed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr         <= '0;
            r_clock_prev <= 1'b0;
        end else begin
            r_clock_prev <= i_clock;
            if (i_strobe) begin
                r_sr <= i_load;
            end else if (w_fall) begin
                r_sr <= {C_FILL_BIT, r_sr[BTN_BITS-1:1]};
            end
        end
    end

    assign o_data = r_sr[0];

endmodule
`default_nettype wire

// File: rtl/joypad_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port_ctrl
// Description : Multi-player NES joypad emulator with autofire, serial ports
//               and a debounced change-IRQ snapshot for the OSD.
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_port_ctrl
    import joypad_pkg::*;
#(
    parameter int   C_PLAYERS       = 2,
    parameter int   C_CLK_HZ        = 21477272,
    parameter int   C_AUTOFIRE_HZ   = 10,
    parameter int   C_DEBOUNCE_BITS = 20,
    parameter logic C_FILL_BIT      = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [C_PLAYERS*BTN_BITS-1:0] i_btn,
    input  logic [C_PLAYERS*BTN_BITS-1:0] i_autofire_mask,
    input  logic                          i_strobe,
    input  logic [C_PLAYERS-1:0]          i_clock,
    output logic [C_PLAYERS-1:0]          o_data,
    output logic [C_PLAYERS*BTN_BITS-1:0] o_btn_state,
    output logic                          o_irq,
    input  logic                          i_irq_ack
);

    localparam int NB     = C_PLAYERS * BTN_BITS;
    localparam int AF_DIV = autofire_div(C_CLK_HZ, C_AUTOFIRE_HZ);
    localparam int AF_W   = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    localparam logic [AF_W-1:0] C_AF_LAST = AF_W'((AF_DIV > 0) ? AF_DIV - 1 : 0);
    localparam int DB_MSB = C_DEBOUNCE_BITS - 1;

    logic [NB-1:0]              r_sync1;
    logic [NB-1:0]              r_sync2;
    logic [AF_W-1:0]            r_af_cnt;
    logic                       r_af_phase;
    logic [NB-1:0]              w_eff_btn;
    logic [C_DEBOUNCE_BITS-1:0] r_db_cnt;
    logic [NB-1:0]              r_btn_state;
    logic                       r_irq;
    logic                       w_change;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Phase stays high when autofire is disabled so masked buttons pass through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (AF_DIV == 0) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (r_af_cnt == C_AF_LAST) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + AF_W'(1);
        end
    end

    assign w_eff_btn = r_sync2 & (~i_autofire_mask | {NB{r_af_phase}});

    for (genvar p = 0; p < C_PLAYERS; p++) begin : g_port
        joypad_shift_port #(
            .C_FILL_BIT (C_FILL_BIT)
        ) u_port (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_strobe (i_strobe),
            .i_clock  (i_clock[p]),
            .i_load   (w_eff_btn[p*BTN_BITS +: BTN_BITS]),
            .o_data   (o_data[p])
        );
    end

    assign w_change = (r_sync2 != r_btn_state) && r_db_cnt[DB_MSB] && !r_irq;

    // A pending difference is re-evaluated every cycle, so the newest value is taken after ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt    <= '0;
            r_btn_state <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (!r_db_cnt[DB_MSB]) begin
                r_db_cnt <= r_db_cnt + C_DEBOUNCE_BITS'(1);
            end
            if (i_irq_ack) begin
                r_irq <= 1'b0;
            end else if (w_change) begin
                r_btn_state <= r_sync2;
                r_irq       <= 1'b1;
                r_db_cnt    <= '0;
            end
        end
    end

    assign o_btn_state = r_btn_state;
    assign o_irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_joypad_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_joypad_port_ctrl
// Description : Scoreboard bench for joypad_port_ctrl (2 players, small timers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joypad_port_ctrl;

    localparam int P  = 2;
    localparam int NB = P * 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] i_btn = '0;
    logic [NB-1:0] i_autofire_mask = '0;
    logic          i_strobe = 1'b0;
    logic [P-1:0]  i_clock = '0;
    logic [P-1:0]  o_data;
    logic [NB-1:0] o_btn_state;
    logic          o_irq;
    logic          i_irq_ack = 1'b0;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [31:0]   exp_q[$];

    joypad_port_ctrl #(
        .C_PLAYERS       (P),
        .C_CLK_HZ        (1000),
        .C_AUTOFIRE_HZ   (10),
        .C_DEBOUNCE_BITS (4),
        .C_FILL_BIT      (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_btn           (i_btn),
        .i_autofire_mask (i_autofire_mask),
        .i_strobe        (i_strobe),
        .i_clock         (i_clock),
        .o_data          (o_data),
        .o_btn_state     (o_btn_state),
        .o_irq           (o_irq),
        .i_irq_ack       (i_irq_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clk_pulse(input int p);
        i_clock[p] = 1'b1;
        tick(1);
        i_clock[p] = 1'b0;
        tick(1);
    endtask

    task automatic load(input logic [NB-1:0] b);
        i_btn = b;
        tick(3);
        i_strobe = 1'b1;
        tick(4);
        i_strobe = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        tick(2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({30'b0, o_data} !== e) begin n_fail++; $display("FAIL reset_o_data got %h want %h", o_data, e); end
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_irq} !== e) begin n_fail++; $display("FAIL reset_o_irq got %h want %h", o_irq, e); end
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL reset_btn_state got %h want %h", o_btn_state, e); end
        reset_n = 1'b1;
        tick(1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({30'b0, o_data} !== e) begin n_fail++; $display("FAIL post_reset_o_data got %h want %h", o_data, e); end
    endtask

    task automatic test_load_shift();
        logic [31:0] e;
        logic [9:0]  seq;
        load(16'h0085);
        seq = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) exp_q.push_back({31'b0, seq[i]});
        for (int i = 0; i < 10; i++) begin
            if (i > 0) clk_pulse(0);
            e = exp_q.pop_front(); n_tests++;
            if ({31'b0, o_data[0]} !== e)
                begin n_fail++; $display("FAIL shift_bit%0d got %h want %h", i, o_data[0], e); end
        end
    endtask

    task automatic test_port_independence();
        logic [31:0] e;
        load(16'h8001);
        repeat (3) clk_pulse(0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL indep_p0_after3 got %h want %h", o_data[0], e); end
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[1]} !== e) begin n_fail++; $display("FAIL indep_p1_unmoved got %h want %h", o_data[1], e); end
        repeat (6) clk_pulse(1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[1]} !== e) begin n_fail++; $display("FAIL indep_p1_edge6 got %h want %h", o_data[1], e); end
        clk_pulse(1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[1]} !== e) begin n_fail++; $display("FAIL indep_p1_edge7 got %h want %h", o_data[1], e); end
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL indep_p0_held got %h want %h", o_data[0], e); end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        load(16'h0002);
        i_strobe = 1'b1;
        tick(1);
        i_clock[0] = 1'b1;
        tick(1);
        i_clock[0] = 1'b0;
        tick(1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL collide_no_shift got %h want %h", o_data[0], e); end
        i_strobe = 1'b0;
        tick(1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL collide_after_strobe got %h want %h", o_data[0], e); end
        clk_pulse(0);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL collide_first_shift got %h want %h", o_data[0], e); end
    endtask

    task automatic test_autofire();
        logic [31:0] e;
        logic        prev;
        int          n;
        int          changes;
        bit          found;
        i_btn = 16'h0001;
        i_autofire_mask = 16'h0001;
        i_strobe = 1'b1;
        tick(3);
        prev = o_data[0];
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (o_data[0] !== prev) found = 1'b1;
        end
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, found} !== e) begin n_fail++; $display("FAIL autofire_toggle_seen got %h want %h", found, e); end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'd50);
            prev = o_data[0];
            n = 0;
            found = 1'b0;
            while (n < 200 && !found) begin
                tick(1);
                n++;
                if (o_data[0] !== prev) found = 1'b1;
            end
            e = exp_q.pop_front(); n_tests++;
            if (n !== int'(e)) begin n_fail++; $display("FAIL autofire_period%0d got %0d want %0d", k, n, e); end
        end
        i_autofire_mask = '0;
        tick(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        changes = 0;
        prev = o_data[0];
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (o_data[0] !== prev) changes++;
            prev = o_data[0];
        end
        e = exp_q.pop_front(); n_tests++;
        if (changes !== int'(e)) begin n_fail++; $display("FAIL autofire_masked_changes got %0d want %0d", changes, e); end
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL autofire_masked_level got %h want %h", o_data[0], e); end
        i_strobe = 1'b0;
        tick(1);
    endtask

    task automatic test_irq();
        logic [31:0] e;
        int          t_chg;
        int          t_irq1;
        bit          found;
        i_btn = '0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(8);
        i_btn = 16'h0010;
        t_chg = cyc;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1);
            if (o_irq === 1'b1) found = 1'b1;
        end
        t_irq1 = cyc;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0010);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, found && (t_irq1 - t_chg >= 3)} !== e)
            begin n_fail++; $display("FAIL irq1_timing got found=%0d delay=%0d want delay>=3", found, t_irq1 - t_chg); end
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL irq1_state got %h want %h", o_btn_state, e); end
        i_btn = 16'h0020;
        tick(10);
        exp_q.push_back(32'h0010);
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL irq_held_state got %h want %h", o_btn_state, e); end
        i_irq_ack = 1'b1;
        tick(1);
        i_irq_ack = 1'b0;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_irq} !== e) begin n_fail++; $display("FAIL irq_ack_clear got %h want %h", o_irq, e); end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1);
            if (o_irq === 1'b1) found = 1'b1;
        end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0020);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, found && (cyc - t_irq1 >= 8)} !== e)
            begin n_fail++; $display("FAIL irq2_timing got found=%0d gap=%0d want gap>=8", found, cyc - t_irq1); end
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL irq2_state got %h want %h", o_btn_state, e); end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        int          t_rel;
        bit          found;
        load(16'h000F);
        repeat (3) clk_pulse(0);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_data[0]} !== e) begin n_fail++; $display("FAIL arst_pre_data got %h want %h", o_data[0], e); end
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_tests++;
        if ({30'b0, o_data} !== e) begin n_fail++; $display("FAIL arst_o_data got %h want %h", o_data, e); end
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, o_irq} !== e) begin n_fail++; $display("FAIL arst_o_irq got %h want %h", o_irq, e); end
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL arst_btn_state got %h want %h", o_btn_state, e); end
        tick(1);
        reset_n = 1'b1;
        t_rel = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1);
            if (o_irq === 1'b1) found = 1'b1;
        end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h000F);
        e = exp_q.pop_front(); n_tests++;
        if ({31'b0, found && (cyc - t_rel >= 8)} !== e)
            begin n_fail++; $display("FAIL arst_irq_timing got found=%0d delay=%0d want delay>=8", found, cyc - t_rel); end
        e = exp_q.pop_front(); n_tests++;
        if ({16'b0, o_btn_state} !== e) begin n_fail++; $display("FAIL arst_irq_state got %h want %h", o_btn_state, e); end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_port_independence();
        test_collision();
        test_autofire();
        test_irq();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
